mul_seq_ctrl: RTL and testbench



---
 rtl/mul_seq_pkg.sv | 45 ++++
 rtl/mul_seq_cell16.sv | 37 +++
 rtl/mul_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared constants for the 32x32 multiply sequencer: op encodings, FSM state codes,
// partial-product indices and the partial-product shift table.
package mul_seq_pkg;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXUU = 2'b01;
    localparam logic [1:0] OP_MULXSS = 2'b10;
    localparam logic [1:0] OP_MULXSU = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_CORR  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Bit 0 of the index selects the A half and bit 1 selects the B half.
    localparam logic [1:0] IDX_LL = 2'd0;
    localparam logic [1:0] IDX_HL = 2'd1;
    localparam logic [1:0] IDX_LH = 2'd2;
    localparam logic [1:0] IDX_HH = 2'd3;

    // Shift codes are in units of 16 bits, giving the table {0,16,16,32}.
    localparam logic [1:0] SH_0  = 2'd0;
    localparam logic [1:0] SH_16 = 2'd1;
    localparam logic [1:0] SH_32 = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [1:0] sh;
    } tag_t;

    function automatic logic [1:0] shift_code(input logic [1:0] idx);
        case (idx)
            IDX_LL:  return SH_0;
            IDX_HL:  return SH_16;
            IDX_LH:  return SH_16;
            default: return SH_32;
        endcase
    endfunction

    function automatic logic [5:0] shift_amt(input logic [1:0] code);
        return {code, 4'b0000};
    endfunction

endpackage

// File: rtl/mul_seq_cell16.sv
// 16x16 unsigned multiplier cell with CELL_LATENCY register stages and an
// asynchronous clear.
module mul_seq_cell16 #(
    parameter int CELL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [31:0] p_o
);

    logic [31:0] prod_c;
    logic [31:0] stage_q [CELL_LATENCY];

    assign prod_c = {16'b0, a_i} * {16'b0, b_i};

    genvar gi;
    generate
        for (gi = 0; gi < CELL_LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) stage_q[gi] <= '0;
                    else       stage_q[gi] <= prod_c;
                end
            end else begin : g_body
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) stage_q[gi] <= '0;
                    else       stage_q[gi] <= stage_q[gi-1];
                end
            end
        end
    endgenerate

    assign p_o = stage_q[CELL_LATENCY-1];

endmodule

// File: rtl/mul_seq_ctrl.sv
// 32x32 multiply sequencer built on one shared 16x16 pipelined cell (MUL/MULXUU/MULXSS/MULXSU).
// Optional MUL_SEQ_SKIP_HI_EN: skip the A_hi*B_hi partial for MUL, finishing one cycle earlier.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int CELL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [1:0]  op,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [31:0] result,
    output logic        busy
);

    logic [2:0]  state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [1:0]  idx_q, idx_d;
    logic [63:0] acc_q, acc_d;

    tag_t        tag_q [CELL_LATENCY];
    tag_t        tag_d [CELL_LATENCY];
    tag_t        issue_tag;
    tag_t        tag_out;

    logic        issue_valid;
    logic        pending;
    logic [1:0]  last_idx;
    logic [15:0] cell_a;
    logic [15:0] cell_b;
    logic [31:0] cell_p;
    logic [31:0] corr_a;
    logic [31:0] corr_b;

    assign issue_valid = (state_q == ST_ISSUE);
    assign issue_tag   = {issue_valid, shift_code(idx_q)};
    assign tag_out     = tag_q[CELL_LATENCY-1];

    assign cell_a = idx_q[0] ? a_q[31:16] : a_q[15:0];
    assign cell_b = idx_q[1] ? b_q[31:16] : b_q[15:0];

`ifdef MUL_SEQ_SKIP_HI_EN
    assign last_idx = (op_q == OP_MUL) ? IDX_LH : IDX_HH;
`else
    assign last_idx = IDX_HH;
`endif

    // Signed correction terms: subtract the other operand from the high word per negative input.
    assign corr_a = a_q[31] ? b_q : 32'd0;
    assign corr_b = b_q[31] ? a_q : 32'd0;

    mul_seq_cell16 #(
        .CELL_LATENCY(CELL_LATENCY)
    ) u_cell (
        .clk   (clk),
        .reset (reset),
        .a_i   (cell_a),
        .b_i   (cell_b),
        .p_o   (cell_p)
    );

    // Tag pipeline runs in lockstep with the cell so each product arrives with its shift.
    genvar gi;
    generate
        for (gi = 0; gi < CELL_LATENCY; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_d[gi] = issue_tag;
            end else begin : g_body
                assign tag_d[gi] = tag_q[gi-1];
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset) tag_q[gi] <= '0;
                else       tag_q[gi] <= tag_d[gi];
            end
        end
    endgenerate

    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < CELL_LATENCY; i++) begin
            pending = pending | tag_d[i].valid;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        idx_d   = idx_q;
        acc_d   = acc_q;

        if (tag_out.valid) begin
            acc_d = acc_q + ({32'd0, cell_p} << shift_amt(tag_out.sh));
        end

        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    a_d     = src1;
                    b_d     = src2;
                    op_d    = op;
                    acc_d   = '0;
                    idx_d   = IDX_LL;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == last_idx) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!pending) begin
                    state_d = ST_CORR;
                end
            end
            ST_CORR: begin
                case (op_q)
                    OP_MULXSS: acc_d[63:32] = acc_q[63:32] - corr_a - corr_b;
                    OP_MULXSU: acc_d[63:32] = acc_q[63:32] - corr_a;
                    default:   acc_d[63:32] = acc_q[63:32];
                endcase
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

    assign start_ready  = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign result_valid = (state_q == ST_DONE);
    assign result       = (state_q != ST_DONE) ? 32'd0 :
                          (op_q == OP_MUL)     ? acc_q[31:0] : acc_q[63:32];

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: one instance at CELL_LATENCY=1 and one at 3,
// table-driven vectors plus hand-written hold and mid-operation reset sequences.
module tb_mul_seq_ctrl;

    localparam logic [1:0] T_MUL = 2'b00;
    localparam logic [1:0] T_XUU = 2'b01;
    localparam logic [1:0] T_XSS = 2'b10;
    localparam logic [1:0] T_XSU = 2'b11;

    logic        clk = 1'b0;
    logic        rst [2];
    logic        sv  [2];
    logic        sr  [2];
    logic [31:0] s1  [2];
    logic [31:0] s2  [2];
    logic [1:0]  opi [2];
    logic        rv  [2];
    logic        rr  [2];
    logic [31:0] res [2];
    logic        bsy [2];

    int lat_of [2] = '{1, 3};

    always #5 clk = ~clk;

    mul_seq_ctrl #(.CELL_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(rst[0]), .start_valid(sv[0]), .start_ready(sr[0]),
        .src1(s1[0]), .src2(s2[0]), .op(opi[0]), .result_valid(rv[0]),
        .result_ready(rr[0]), .result(res[0]), .busy(bsy[0])
    );

    mul_seq_ctrl #(.CELL_LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset(rst[1]), .start_valid(sv[1]), .start_ready(sr[1]),
        .src1(s1[1]), .src2(s2[1]), .op(opi[1]), .result_valid(rv[1]),
        .result_ready(rr[1]), .result(res[1]), .busy(bsy[1])
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    exp_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: extend each operand per op, multiply modulo 2^64, pick the word.
    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ax, bx, p;
        ax = (o == T_XSS || o == T_XSU) ? {{32{a[31]}}, a} : {32'd0, a};
        bx = (o == T_XSS)               ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ax * bx;
        return (o == T_MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_lat(input int d, input logic [1:0] o);
        int l;
        l = 6 + lat_of[d];
`ifdef MUL_SEQ_SKIP_HI_EN
        if (o == T_MUL) l = l - 1;
`endif
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge; the following cycle is cycle n.
    task automatic issue(input int d, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        exp_t e;
        check("start_ready_idle", {63'd0, sr[d]}, 64'd1);
        sv[d]  = 1'b1;
        opi[d] = o;
        s1[d]  = a;
        s2[d]  = b;
        e.res  = exp;
        e.lat  = exp_lat(d, o);
        sb.push_back(e);
        tick();
        sv[d]  = 1'b0;
        s1[d]  = $urandom;
        s2[d]  = $urandom;
        opi[d] = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_result(input int d, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b);
        int   c;
        exp_t e;
        c = 1;
        while (!rv[d] && c < 40) begin
            tick();
            c++;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            if (!rv[d]) begin
                check("result_timeout", 64'd0, 64'd1);
            end else begin
                check("latency", 64'(c), 64'(e.lat));
                check("result", {32'd0, res[d]}, {32'd0, e.res});
                check("busy_in_done", {63'd0, bsy[d]}, 64'd1);
            end
            $display("txn dut%0d op=%0d a=%08h b=%08h result=%08h expect=%08h cycles=%0d",
                     d, o, a, b, res[d], e.res, c);
        end
    endtask

    task automatic accept(input int d);
        rr[d] = 1'b1;
        tick();
        rr[d] = 1'b0;
        check("valid_drop", {63'd0, rv[d]}, 64'd0);
        check("ready_back", {63'd0, sr[d]}, 64'd1);
    endtask

    task automatic run(input int d, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        issue(d, o, a, b, exp);
        wait_result(d, o, a, b);
        accept(d);
    endtask

    task automatic check_reset_outputs(input int d);
        check("rst_result_valid", {63'd0, rv[d]}, 64'd0);
        check("rst_result", {32'd0, res[d]}, 64'd0);
        check("rst_busy", {63'd0, bsy[d]}, 64'd0);
        check("rst_start_ready", {63'd0, sr[d]}, 64'd1);
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{T_MUL, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001};
        vecs[1] = '{T_XUU, 32'h0000FFFF, 32'h0000FFFF, 32'h00000000};
        vecs[2] = '{T_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[3] = '{T_XUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[4] = '{T_XSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[5] = '{T_XSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[6] = '{T_XUU, 32'h00010000, 32'h00010000, 32'h00000001};
        vecs[7] = '{T_MUL, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[8] = '{T_XSS, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; sv[d] = 1'b0; rr[d] = 1'b0;
            s1[d] = '0; s2[d] = '0; opi[d] = '0;
        end
        #2;
        for (int d = 0; d < 2; d++) check_reset_outputs(d);
        tick();
        tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            run(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            logic [1:0]  o;
            a = $urandom;
            b = $urandom;
            o = 2'(i % 4);
            run(0, o, a, b, ref_model(o, a, b));
        end

        // Hold DONE for five cycles with a competing start request.
        issue(0, T_XUU, 32'h00010000, 32'h00010000, 32'h00000001);
        wait_result(0, T_XUU, 32'h00010000, 32'h00010000);
        for (int k = 0; k < 5; k++) begin
            sv[0]  = 1'b1;
            opi[0] = T_MUL;
            s1[0]  = 32'h00000003;
            s2[0]  = 32'h00000005;
            tick();
            check("hold_result", {32'd0, res[0]}, 64'h1);
            check("hold_valid", {63'd0, rv[0]}, 64'd1);
            check("hold_start_ready", {63'd0, sr[0]}, 64'd0);
        end
        rr[0] = 1'b1;
        tick();
        rr[0] = 1'b0;
        sv[0] = 1'b0;
        check("handshake_valid_drop", {63'd0, rv[0]}, 64'd0);
        check("handshake_no_start", {63'd0, bsy[0]}, 64'd0);
        tick();
        check("idle_after_handshake", {63'd0, bsy[0]}, 64'd0);

        // Reset in cycle n+3 of an operation, then a fresh signed op.
        issue(0, T_XUU, 32'h12345678, 32'h9ABCDEF0, ref_model(T_XUU, 32'h12345678, 32'h9ABCDEF0));
        tick();
        tick();
        rst[0] = 1'b1;
        #1;
        check_reset_outputs(0);
        if (sb.size() != 0) void'(sb.pop_back());
        tick();
        rst[0] = 1'b0;
        tick();
        check("idle_after_reset", {63'd0, bsy[0]}, 64'd0);
        run(0, T_XSS, 32'h80000000, 32'h00000002, 32'hFFFFFFFF);

        // Three-stage cell instance.
        tick();
        run(1, T_XSS, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF);
        run(1, T_MUL, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            run(1, 2'(i), a, b, ref_model(2'(i), a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
